lsu: RTL and testbench
======================

# lsu

Load-store unit for the RV32I single-cycle core: sits directly upstream of the writeback mux and produces `o_ld_data` from the ALU-computed address. Owns the data memory and the memory-mapped I/O registers (LEDs, 7-segment, LCD, switches), performs byte/half/word stores on the clock edge and combinational sign- or zero-extended loads within the same cycle.

## Interface
- `DMEM_ADDR_W`, 11, word-address width of data memory (2^11 words = 8 KiB).
- `i_clk`  in  1  core clock; all state updates on rising edge.
- `i_rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `i_lsu_addr`  in  32  byte address (ALU result).
- `i_st_data`  in  32  store data (rs2).
- `i_lsu_wren`  in  1  store enable.
- `i_funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- `i_io_sw`  in  32  board switches, asynchronous to `i_clk`.
- `o_ld_data`  out  32  extended load result to writeback mux.
- `o_misalign`  out  1  current access misaligned or illegal funct3 (combinational).
- `o_io_ledr`, `o_io_ledg`, `o_io_lcd`  out  32 each  register contents.
- `o_io_hex0`..`o_io_hex7`  out  7 each  7-segment digit drives.

## Operation
- Memory map (decode on full 32-bit address; anything else is unmapped):
  - DMEM: 0x0000_2000 – 0x0000_2000 + 4·2^DMEM_ADDR_W − 1, read/write.
  - LEDR 0x1000_0000, LEDG 0x1000_1000, HEXLO 0x1000_2000, HEXHI 0x1000_3000, LCD 0x1000_4000: one 32-bit read/write register each, byte/half lanes addressable (offset 0..3).
  - SW 0x1001_0000: read-only; stores ignored.
- Little-endian. Byte lane = addr[1:0]; half lane = addr[1].
- Alignment: H requires addr[0]=0; W requires addr[1:0]=00. Misaligned or funct3 ∉ {000,001,010,100,101} (stores: ∉ {000,001,010}) → `o_misalign`=1, store suppressed, `o_ld_data`=0.
- Store: on rising edge with `i_rst_n`=1, `i_lsu_wren`=1, aligned, mapped, writable → write only the addressed byte lanes; other lanes unchanged.
- Load: combinational mux of addressed word, lane select, then extension: B/H sign-extend bit 7/15; BU/HU zero-extend; W passthrough. Unmapped load → 0.
- HEX: `o_io_hexN` = HEXLO byte N bits [6:0] for N=0..3, HEXHI byte N−4 bits [6:0] for N=4..7. Bit 7 of each byte is stored and read back but not driven.
- Reset (edge with `i_rst_n`=0): LEDR, LEDG, HEXLO, HEXHI, LCD, switch sync flops → 0; all I/O outputs therefore 0. DMEM not reset (content X until written). Stores in a reset cycle are dropped.

## Timing
- Load latency 0 cycles (same cycle as address). Store latency 1 edge.
- Same-cycle load and store to same address: load returns old data; next cycle returns new data.
- I/O outputs are register outputs: update exactly one edge after the store cycle.
- Switch read latency: see Configuration.
- Reset asserted mid-program: registers clear on that edge regardless of `i_lsu_wren`; DMEM retains contents.

## Configuration
- `LSU_SW_SYNC_EN` defined: `i_io_sw` passes through a 2-flop synchronizer (reset 0); SW load reflects a switch change 2 edges later.
- Undefined: SW load returns `i_io_sw` combinationally, 0-cycle latency, no flops.

## Test plan
- Reset: drive `i_rst_n`=0 one edge with `i_lsu_wren`=1, SW to LEDR 0xFFFF_FFFF → LEDR, LEDG, LCD, all hex = 0 after edge.
- Byte/half extension: SW 0x8070_F0A5 to 0x2000; LB 0x2000 → 0xFFFF_FFA5, LBU 0x2000 → 0x0000_00A5, LH 0x2002 → 0xFFFF_8070, LHU 0x2002 → 0x0000_8070, LW → 0x8070_F0A5.
- Lane merge: SW 0x1122_3344 to 0x2004, then SB 0xEE to 0x2005 → LW 0x2004 = 0x1122_EE44.
- Misalign/unmapped: SW 0xDEAD_BEEF to 0x2002 → `o_misalign`=1, 0x2000 word unchanged; LW 0x0000_0000 → 0, `o_misalign`=0.
- HEX: SW 0x7F06_5B3F to 0x1000_2000 → hex0=0x3F, hex1=0x5B, hex2=0x06, hex3=0x7F one edge later; hex4..7=0.
- Switches: `i_io_sw`=0x0000_00A5, LW 0x1001_0000 → 0xA5 after 2 edges with `LSU_SW_SYNC_EN`, same cycle without; SW to 0x1001_0000 has no effect.

Source files
------------

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load-store unit: data memory, memory-mapped I/O registers, extended loads.
// Optional switch synchronizer enabled by defining LSU_SW_SYNC_EN.
module lsu #(
    parameter int DMEM_ADDR_W = 11
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_io_sw,
    output logic [31:0] o_ld_data,
    output logic        o_misalign,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [31:0] o_io_lcd,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7
);

    localparam logic [31:0] DMEM_BASE  = 32'h0000_2000;
    localparam logic [31:0] DMEM_SIZE  = 32'd4 << DMEM_ADDR_W;
    localparam logic [31:0] LEDR_ADDR  = 32'h1000_0000;
    localparam logic [31:0] LEDG_ADDR  = 32'h1000_1000;
    localparam logic [31:0] HEXLO_ADDR = 32'h1000_2000;
    localparam logic [31:0] HEXHI_ADDR = 32'h1000_3000;
    localparam logic [31:0] LCD_ADDR   = 32'h1000_4000;
    localparam logic [31:0] SW_ADDR    = 32'h1001_0000;

    logic [31:0] dmem [0:(1<<DMEM_ADDR_W)-1];
    logic [31:0] ledr, ledg, hexlo, hexhi, lcd, sw_val;
    logic [31:0] dmem_off, wdata, rword, lane;
    logic [DMEM_ADDR_W-1:0] idx;
    logic [3:0]  be;
    logic        hit_dmem, hit_ledr, hit_ledg, hit_hexlo, hit_hexhi, hit_lcd, hit_sw;
    logic        ld_ok, st_ok, st_en;

    // Wrapping subtraction makes addresses below the base fail the size test too.
    assign dmem_off  = i_lsu_addr - DMEM_BASE;
    assign hit_dmem  = dmem_off < DMEM_SIZE;
    assign idx       = dmem_off[DMEM_ADDR_W+1:2];
    assign hit_ledr  = i_lsu_addr[31:2] == LEDR_ADDR[31:2];
    assign hit_ledg  = i_lsu_addr[31:2] == LEDG_ADDR[31:2];
    assign hit_hexlo = i_lsu_addr[31:2] == HEXLO_ADDR[31:2];
    assign hit_hexhi = i_lsu_addr[31:2] == HEXHI_ADDR[31:2];
    assign hit_lcd   = i_lsu_addr[31:2] == LCD_ADDR[31:2];
    assign hit_sw    = i_lsu_addr[31:2] == SW_ADDR[31:2];

    always_comb begin
        ld_ok = 1'b0;
        st_ok = 1'b0;
        case (i_funct3)
            3'b000:  begin ld_ok = 1'b1;                     st_ok = 1'b1; end
            3'b001:  begin ld_ok = !i_lsu_addr[0];           st_ok = !i_lsu_addr[0]; end
            3'b010:  begin ld_ok = i_lsu_addr[1:0] == 2'b00; st_ok = i_lsu_addr[1:0] == 2'b00; end
            3'b100:  ld_ok = 1'b1;
            3'b101:  ld_ok = !i_lsu_addr[0];
            default: ;
        endcase
    end

    assign o_misalign = i_lsu_wren ? !st_ok : !ld_ok;
    assign st_en      = i_lsu_wren && !o_misalign;

    always_comb begin
        be    = 4'b1111;
        wdata = i_st_data;
        case (i_funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << i_lsu_addr[1:0];
                wdata = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] lanes);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = lanes[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return r;
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ledr  <= '0;
            ledg  <= '0;
            hexlo <= '0;
            hexhi <= '0;
            lcd   <= '0;
        end else if (st_en) begin
            if (hit_ledr)  ledr  <= merge(ledr, wdata, be);
            if (hit_ledg)  ledg  <= merge(ledg, wdata, be);
            if (hit_hexlo) hexlo <= merge(hexlo, wdata, be);
            if (hit_hexhi) hexhi <= merge(hexhi, wdata, be);
            if (hit_lcd)   lcd   <= merge(lcd, wdata, be);
        end
    end

    // DMEM keeps its contents through reset; only the store itself is gated.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && st_en && hit_dmem) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) dmem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

`ifdef LSU_SW_SYNC_EN
    logic [31:0] sw_meta;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sw_meta <= '0;
            sw_val  <= '0;
        end else begin
            sw_meta <= i_io_sw;
            sw_val  <= sw_meta;
        end
    end
`else
    assign sw_val = i_io_sw;
`endif

    always_comb begin
        rword = '0;
        if (hit_dmem)       rword = dmem[idx];
        else if (hit_ledr)  rword = ledr;
        else if (hit_ledg)  rword = ledg;
        else if (hit_hexlo) rword = hexlo;
        else if (hit_hexhi) rword = hexhi;
        else if (hit_lcd)   rword = lcd;
        else if (hit_sw)    rword = sw_val;
    end

    assign lane = rword >> {i_lsu_addr[1:0], 3'b000};

    always_comb begin
        o_ld_data = '0;
        if (!o_misalign) begin
            case (i_funct3)
                3'b000:  o_ld_data = {{24{lane[7]}}, lane[7:0]};
                3'b001:  o_ld_data = {{16{lane[15]}}, lane[15:0]};
                3'b010:  o_ld_data = rword;
                3'b100:  o_ld_data = {24'd0, lane[7:0]};
                3'b101:  o_ld_data = {16'd0, lane[15:0]};
                default: o_ld_data = '0;
            endcase
        end
    end

    assign o_io_ledr = ledr;
    assign o_io_ledg = ledg;
    assign o_io_lcd  = lcd;
    assign o_io_hex0 = hexlo[6:0];
    assign o_io_hex1 = hexlo[14:8];
    assign o_io_hex2 = hexlo[22:16];
    assign o_io_hex3 = hexlo[30:24];
    assign o_io_hex4 = hexhi[6:0];
    assign o_io_hex5 = hexhi[14:8];
    assign o_io_hex6 = hexhi[22:16];
    assign o_io_hex7 = hexhi[30:24];

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu (builds with or without LSU_SW_SYNC_EN).
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, st_data, io_sw;
    logic        wren;
    logic [2:0]  f3;
    logic [31:0] ld_data, ledr, ledg, lcd;
    logic        misalign;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

    int checks = 0;
    int failures = 0;

    localparam logic [2:0] FB = 3'b000, FH = 3'b001, FW = 3'b010, FBU = 3'b100, FHU = 3'b101;

    always #5 clk = ~clk;

    lsu dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_lsu_addr(addr), .i_st_data(st_data),
        .i_lsu_wren(wren), .i_funct3(f3), .i_io_sw(io_sw),
        .o_ld_data(ld_data), .o_misalign(misalign),
        .o_io_ledr(ledr), .o_io_ledg(ledg), .o_io_lcd(lcd),
        .o_io_hex0(hex0), .o_io_hex1(hex1), .o_io_hex2(hex2), .o_io_hex3(hex3),
        .o_io_hex4(hex4), .o_io_hex5(hex5), .o_io_hex6(hex6), .o_io_hex7(hex7)
    );

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        @(negedge clk);
        addr = a; st_data = d; f3 = f; wren = 1'b1;
        @(posedge clk);
        #1 wren = 1'b0;
    endtask

    task automatic set_load(input logic [31:0] a, input logic [2:0] f);
        wren = 1'b0; addr = a; f3 = f;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; wren = 1'b0; addr = '0; st_data = '0; f3 = FW; io_sw = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ledr !== 32'd0) begin failures++; $display("FAIL rst_ledr got=%h exp=0", ledr); end
        checks++; if (ledg !== 32'd0) begin failures++; $display("FAIL rst_ledg got=%h exp=0", ledg); end
        checks++; if (lcd !== 32'd0) begin failures++; $display("FAIL rst_lcd got=%h exp=0", lcd); end
        checks++; if ({hex0, hex3, hex4, hex7} !== 28'd0) begin failures++; $display("FAIL rst_hex got=%h exp=0", {hex0, hex3, hex4, hex7}); end
        rst_n = 1'b1;
        do_store(32'h1000_0000, 32'h1234_5678, FW);
        checks++; if (ledr !== 32'h1234_5678) begin failures++; $display("FAIL ledr_store got=%h exp=12345678", ledr); end
        do_store(32'h1000_4000, 32'hA5A5_0F0F, FW);
        do_store(32'h1000_2000, 32'hFFFF_FFFF, FW);
        checks++; if (hex0 !== 7'h7F) begin failures++; $display("FAIL hex0_pre got=%h exp=7f", hex0); end
        do_store(32'h0000_2008, 32'hCAFE_BABE, FW);
        // reset edge with a store to LEDR pending: register clears, store dropped
        @(negedge clk);
        rst_n = 1'b0; wren = 1'b1; addr = 32'h1000_0000; st_data = 32'hFFFF_FFFF; f3 = FW;
        @(posedge clk);
        #1;
        checks++; if (ledr !== 32'd0) begin failures++; $display("FAIL rst_wr_ledr got=%h exp=0", ledr); end
        checks++; if (lcd !== 32'd0) begin failures++; $display("FAIL rst_wr_lcd got=%h exp=0", lcd); end
        checks++; if (hex0 !== 7'd0) begin failures++; $display("FAIL rst_wr_hex0 got=%h exp=0", hex0); end
        // reset edge with a DMEM store: dropped, DMEM retained
        @(negedge clk);
        addr = 32'h0000_2008; st_data = 32'h0;
        @(posedge clk);
        #1 wren = 1'b0; rst_n = 1'b1;
        set_load(32'h0000_2008, FW);
        checks++; if (ld_data !== 32'hCAFE_BABE) begin failures++; $display("FAIL dmem_keep got=%h exp=cafebabe", ld_data); end
    endtask

    task automatic test_extension;
        do_store(32'h0000_2000, 32'h8070_F0A5, FW);
        set_load(32'h0000_2000, FB);
        checks++; if (ld_data !== 32'hFFFF_FFA5) begin failures++; $display("FAIL lb got=%h exp=ffffffa5", ld_data); end
        set_load(32'h0000_2000, FBU);
        checks++; if (ld_data !== 32'h0000_00A5) begin failures++; $display("FAIL lbu got=%h exp=000000a5", ld_data); end
        set_load(32'h0000_2002, FH);
        checks++; if (ld_data !== 32'hFFFF_8070) begin failures++; $display("FAIL lh got=%h exp=ffff8070", ld_data); end
        set_load(32'h0000_2002, FHU);
        checks++; if (ld_data !== 32'h0000_8070) begin failures++; $display("FAIL lhu got=%h exp=00008070", ld_data); end
        set_load(32'h0000_2000, FW);
        checks++; if (ld_data !== 32'h8070_F0A5) begin failures++; $display("FAIL lw got=%h exp=8070f0a5", ld_data); end
        set_load(32'h0000_2001, FB);
        checks++; if (ld_data !== 32'hFFFF_FFF0) begin failures++; $display("FAIL lb1 got=%h exp=fffffff0", ld_data); end
        set_load(32'h0000_2003, FBU);
        checks++; if (ld_data !== 32'h0000_0080) begin failures++; $display("FAIL lbu3 got=%h exp=00000080", ld_data); end
    endtask

    task automatic test_lane_merge;
        do_store(32'h0000_2004, 32'h1122_3344, FW);
        do_store(32'h0000_2005, 32'h0000_00EE, FB);
        set_load(32'h0000_2004, FW);
        checks++; if (ld_data !== 32'h1122_EE44) begin failures++; $display("FAIL sb_merge got=%h exp=1122ee44", ld_data); end
        do_store(32'h0000_2006, 32'h0000_BEEF, FH);
        set_load(32'h0000_2004, FW);
        checks++; if (ld_data !== 32'hBEEF_EE44) begin failures++; $display("FAIL sh_merge got=%h exp=beefee44", ld_data); end
        // top of DMEM
        do_store(32'h0000_3FFC, 32'h0BAD_F00D, FW);
        set_load(32'h0000_3FFC, FW);
        checks++; if (ld_data !== 32'h0BAD_F00D) begin failures++; $display("FAIL dmem_top got=%h exp=0badf00d", ld_data); end
    endtask

    task automatic test_back_to_back;
        // same-cycle load/store: old data now, new data after the edge
        @(negedge clk);
        addr = 32'h0000_2004; st_data = 32'h5566_7788; f3 = FW; wren = 1'b1;
        #1;
        checks++; if (ld_data !== 32'hBEEF_EE44) begin failures++; $display("FAIL rw_old got=%h exp=beefee44", ld_data); end
        @(posedge clk);
        #1 wren = 1'b0;
        #1;
        checks++; if (ld_data !== 32'h5566_7788) begin failures++; $display("FAIL rw_new got=%h exp=55667788", ld_data); end
    endtask

    task automatic test_misalign;
        @(negedge clk);
        addr = 32'h0000_2002; st_data = 32'hDEAD_BEEF; f3 = FW; wren = 1'b1;
        #1;
        checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL mis_sw got=%b exp=1", misalign); end
        checks++; if (ld_data !== 32'd0) begin failures++; $display("FAIL mis_data got=%h exp=0", ld_data); end
        @(posedge clk);
        #1 wren = 1'b0;
        set_load(32'h0000_2000, FW);
        checks++; if (ld_data !== 32'h8070_F0A5) begin failures++; $display("FAIL mis_nowr got=%h exp=8070f0a5", ld_data); end
        set_load(32'h0000_0000, FW);
        checks++; if (ld_data !== 32'd0 || misalign !== 1'b0) begin failures++; $display("FAIL unmapped got=%h/%b exp=0/0", ld_data, misalign); end
        set_load(32'h0000_2001, FHU);
        checks++; if (misalign !== 1'b1 || ld_data !== 32'd0) begin failures++; $display("FAIL mis_lhu got=%b/%h exp=1/0", misalign, ld_data); end
        set_load(32'h0000_2000, 3'b011);
        checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL bad_f3 got=%b exp=1", misalign); end
        do_store(32'h0000_2000, 32'h0000_0011, FBU);
        set_load(32'h0000_2000, FW);
        checks++; if (ld_data !== 32'h8070_F0A5) begin failures++; $display("FAIL st_bu got=%h exp=8070f0a5", ld_data); end
    endtask

    task automatic test_hex;
        @(negedge clk);
        addr = 32'h1000_2000; st_data = 32'h7F06_5B3F; f3 = FW; wren = 1'b1;
        #1;
        checks++; if (hex0 !== 7'd0) begin failures++; $display("FAIL hex_early got=%h exp=0", hex0); end
        @(posedge clk);
        #1 wren = 1'b0;
        checks++; if ({hex3, hex2, hex1, hex0} !== {7'h7F, 7'h06, 7'h5B, 7'h3F}) begin
            failures++; $display("FAIL hex_lo got=%h %h %h %h exp=7f 06 5b 3f", hex3, hex2, hex1, hex0); end
        checks++; if ({hex7, hex6, hex5, hex4} !== 28'd0) begin failures++; $display("FAIL hex_hi0 got=%h exp=0", {hex7, hex6, hex5, hex4}); end
        do_store(32'h1000_3002, 32'h0000_1234, FH);
        checks++; if ({hex7, hex6, hex5, hex4} !== {7'h12, 7'h34, 7'h00, 7'h00}) begin
            failures++; $display("FAIL hex_hi got=%h exp=%h", {hex7, hex6, hex5, hex4}, {7'h12, 7'h34, 14'd0}); end
        do_store(32'h1000_2000, 32'h0000_00BF, FB);
        checks++; if (hex0 !== 7'h3F) begin failures++; $display("FAIL hex_bit7 got=%h exp=3f", hex0); end
        set_load(32'h1000_2000, FBU);
        checks++; if (ld_data !== 32'h0000_00BF) begin failures++; $display("FAIL hex_rd got=%h exp=000000bf", ld_data); end
        do_store(32'h1000_1000, 32'h0000_00C3, FB);
        checks++; if (ledg !== 32'h0000_00C3) begin failures++; $display("FAIL ledg got=%h exp=000000c3", ledg); end
    endtask

    task automatic test_switches;
        @(negedge clk);
        io_sw = 32'h0000_00A5; addr = 32'h1001_0000; f3 = FW; wren = 1'b0;
        #1;
`ifdef LSU_SW_SYNC_EN
        checks++; if (ld_data !== 32'd0) begin failures++; $display("FAIL sw_e0 got=%h exp=0", ld_data); end
        @(posedge clk);
        #1;
        checks++; if (ld_data !== 32'd0) begin failures++; $display("FAIL sw_e1 got=%h exp=0", ld_data); end
        @(posedge clk);
        #1;
`endif
        checks++; if (ld_data !== 32'h0000_00A5) begin failures++; $display("FAIL sw_rd got=%h exp=000000a5", ld_data); end
        do_store(32'h1001_0000, 32'h0000_0000, FW);
        set_load(32'h1001_0000, FW);
        checks++; if (ld_data !== 32'h0000_00A5) begin failures++; $display("FAIL sw_ro got=%h exp=000000a5", ld_data); end
    endtask

    initial begin
        test_reset();
        test_extension();
        test_lane_merge();
        test_back_to_back();
        test_misalign();
        test_hex();
        test_switches();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
